// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the fetch front-end: instruction word, queued fetch entry,
// and the instruction field positions dispatch slices with.
package inst_fetch_queue_pkg;
  typedef logic [31:0] inst_t;

  typedef struct packed {
    logic [31:0] pc;
    inst_t       inst;
  } fetch_entry_t;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch queue bus: icache request/response, redirect, and dispatch dequeue port.
interface inst_fetch_queue_if #(parameter int DEPTH = 8);
  import inst_fetch_queue_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req_valid;
  logic [31:0]   imem_req_addr;
  inst_t         imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          deq_valid;
  logic          deq_ready;
  inst_t         deq_inst;
  logic [31:0]   deq_pc;
  logic [CW-1:0] count;

  modport master (
    output imem_req_valid, imem_req_addr, deq_valid, deq_inst, deq_pc, count,
    input  imem_rdata, redirect_valid, redirect_pc, deq_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, deq_valid, deq_inst, deq_pc, count,
    output imem_rdata, redirect_valid, redirect_pc, deq_ready
  );
endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Ring buffer of fetch entries with flush; storage resets so the head reads zero.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       CLOCK_50,
  input  logic                       RSTN_N,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wr_entry,
  output fetch_entry_t               head_entry,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head, tail;

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wr_entry;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_entry = mem[head];
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: one icache request per cycle, credit-limited so a
// response always has a slot; redirect flushes and restarts fetch.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic             CLOCK_50,
  input logic             RSTN_N,
  inst_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc, pending_pc;
  logic          pending;
  logic          issue, push, pop;
  logic [CW:0]   occ;
  logic [CW-1:0] count;
  fetch_entry_t  head_entry, wr_entry;

  assign pop  = bus.deq_valid && bus.deq_ready;
  assign push = pending && !bus.redirect_valid;

  // Occupancy after this cycle's pop, counting the in-flight response as taken.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, pending} - {{CW{1'b0}}, pop};
  assign issue = RSTN_N && !bus.redirect_valid && (occ < DEPTH_W);

  assign bus.imem_req_valid = issue;
  assign bus.imem_req_addr  = RSTN_N ? fetch_pc : '0;
  assign bus.deq_valid      = (count != '0) && !bus.redirect_valid;
  assign bus.deq_inst       = head_entry.inst;
  assign bus.deq_pc         = head_entry.pc;
  assign bus.count          = count;

  assign wr_entry = '{pc: pending_pc, inst: bus.imem_rdata};

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      pending  <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + 32'd1;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLOCK_50   (CLOCK_50),
    .RSTN_N     (RSTN_N),
    .push       (push),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .wr_entry   (wr_entry),
    .head_entry (head_entry),
    .count      (count)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed + random bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;
  localparam int DEPTH = 8;

  logic CLOCK_50 = 1'b0;
  logic RSTN_N;
  always #5 CLOCK_50 = ~CLOCK_50;

  inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .CLOCK_50 (CLOCK_50),
    .RSTN_N   (RSTN_N),
    .bus      (bus)
  );

  fetch_entry_t mq[$];
  logic        m_pend;
  logic [31:0] m_pend_pc, m_fpc;
  logic        prev_req;
  logic [31:0] prev_addr;
  bit          nop_mode;
  int          n_checks, n_pass, n_fail;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (nop_mode && a[3:0] == 4'hB) return 32'd0;
    return a + 32'd100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend   = 1'b0;
    m_pend_pc = '0;
    m_fpc    = 32'd0;
    prev_req = 1'b0;
    prev_addr = '0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_req_addr",  bus.imem_req_addr, 32'd0);
    chk("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
    chk("rst_deq_inst",  bus.deq_inst, 32'd0);
    chk("rst_deq_pc",    bus.deq_pc, 32'd0);
    chk("rst_count",     32'(bus.count), 32'd0);
  endtask

  // Called just after a rising edge; pulls reset low with no edge in between.
  task automatic do_reset();
    bus.deq_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    #2;
    RSTN_N = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    RSTN_N = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic edv, epop, eiss;
    bus.deq_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_rdata     = prev_req ? word(prev_addr) : $urandom();
    @(negedge CLOCK_50);
    edv  = (mq.size() != 0) && !rv;
    epop = edv && rdy;
    eiss = !rv && ((mq.size() + int'(m_pend) - int'(epop)) < DEPTH);
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("count_bound", 32'(bus.count <= DEPTH), 32'd1);
    chk("deq_valid", 32'(bus.deq_valid), 32'(edv));
    if (edv) begin
      chk("deq_pc",   bus.deq_pc,   mq[0].pc);
      chk("deq_inst", bus.deq_inst, mq[0].inst);
    end
    chk("req_valid", 32'(bus.imem_req_valid), 32'(eiss));
    if (eiss) chk("req_addr", bus.imem_req_addr, m_fpc);
    prev_req  = bus.imem_req_valid;
    prev_addr = bus.imem_req_addr;
    if (rv) begin
      mq.delete();
      m_pend = 1'b0;
      m_fpc  = rpc;
    end else begin
      if (epop) void'(mq.pop_front());
      if (m_pend) mq.push_back('{pc: m_pend_pc, inst: word(m_pend_pc)});
      m_pend = eiss;
      if (eiss) begin
        m_pend_pc = m_fpc;
        m_fpc     = m_fpc + 32'd1;
      end
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic rdy, rv;
    logic [31:0] rpc;
    n_checks = 0; n_pass = 0; n_fail = 0;
    nop_mode = 1'b0;
    RSTN_N = 1'b0;
    bus.deq_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_rdata = '0;
    model_reset();
    #12;
    chk_reset_outputs();
    @(posedge CLOCK_50); #1;
    RSTN_N = 1'b1;

    // streaming with dispatch always ready
    repeat (20) cycle(1'b1, 1'b0, 32'd0);

    // fill to full, single pop while full, then drain
    do_reset();
    repeat (14) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    repeat (3) cycle(1'b0, 1'b0, 32'd0);
    repeat (12) cycle(1'b1, 1'b0, 32'd0);

    // redirect with 5 queued and PC 5 in flight
    do_reset();
    repeat (6) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h40);
    repeat (6) cycle(1'b1, 1'b0, 32'd0);

    // PC wrap after redirect to the top of the address space
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
    repeat (6) cycle(1'b1, 1'b0, 32'd0);

    // reset mid-stream with four entries queued
    guard = 0;
    while (mq.size() != 4 && guard < 20) begin
      cycle(1'b0, 1'b0, 32'd0);
      guard++;
    end
    chk("reach_count4", 32'(bus.count), 32'd4);
    do_reset();
    repeat (10) cycle(1'b1, 1'b0, 32'd0);

    // random traffic with NOP words and occasional redirects
    nop_mode = 1'b1;
    repeat (400) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                        : $urandom();
      cycle(rdy, rv, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
